hazard_track: RTL
=================

HAZARD_TRACK -- requirements
Module: hazard_track

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning), clock and reset first:
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 FWRD_EN  input  1  forwarding enabled; it changes the stall rules.
REQ-005 freeze  input  1  memory not ready; all stage registers hold.
REQ-006 flush  input  1  branch taken; the ID instruction enters EXE as a bubble.
REQ-007 WB_EN_ID, MEM_R_EN_ID  input  1 each  the ID instruction writes a register / is a load.
REQ-008 dest_ID, src1_ID, src2_ID  input  4 each  ID destination and source register numbers.
REQ-009 src1_used_ID, src2_used_ID  input  1 each  the corresponding ID source is actually read.
REQ-010 hazard  output  1  stall request to the PC/IF/ID registers, combinational.
REQ-011 WB_EN_MEM, WB_EN_WB  output  1 each  registered write-enable of the MEM/WB stage instruction.
REQ-012 dest_MEM, dest_WB  output  4 each  registered destination of the MEM/WB stage instruction.
REQ-013 src1_FWRD, src2_FWRD  output  4 each  registered sources of the EXE stage instruction, for forwarding select.
REQ-014 stall_cnt  output  16  saturating count of hazard stall cycles.

Function
REQ-015 The block SHALL hold three shadow stage registers, EXE, MEM and WB; each holds wb_en (1 bit), mem_r (1 bit) and dest (4 bits); EXE also holds src1 and src2.
REQ-016 On a rising clk edge with freeze=0, state SHALL advance as follows: WB<=MEM; MEM<=EXE; EXE<=ID fields.
REQ-017 On a rising clk edge with freeze=1, all stage registers and stall_cnt SHALL hold their values.
REQ-018 When EXE loads from ID with hazard=1 or flush=1, the block SHALL clear EXE wb_en and mem_r to 0; dest, src1 and src2 SHALL still load from ID.
REQ-019 Define match_X(s) = X.wb_en & src_used(s) & (X.dest == s), for stage X in {EXE, MEM} and each source s of ID.
REQ-020 With FWRD_EN=0, hazard SHALL be 1 iff match_EXE or match_MEM is true for src1 or for src2.
REQ-021 With FWRD_EN=1, hazard SHALL be 1 iff EXE.mem_r=1 and match_EXE is true for src1 or for src2 (load-use case only).
REQ-022 The WB stage SHALL never cause a hazard, because the register file writes on the falling edge.
REQ-023 The hazard output SHALL be combinational from the current inputs and state; it SHALL NOT be masked by freeze or flush.
REQ-024 When hazard=1 and flush=1 occur together, flush semantics SHALL apply: EXE gets a bubble and stall_cnt still counts the cycle.
REQ-025 stall_cnt SHALL increment by 1 on each edge with hazard=1 and freeze=0.
REQ-026 stall_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-027 The outputs WB_EN_MEM, dest_MEM, WB_EN_WB, dest_WB, src1_FWRD and src2_FWRD SHALL be direct register outputs, with no combinational path from any input.
REQ-028 A two-instruction dependency SHALL resolve as follows: a non-load producer in EXE followed by a consumer in ID gives no stall with FWRD_EN=1, and up to 2 stall cycles with FWRD_EN=0.

Reset
REQ-029 rst=1 SHALL immediately (asynchronously) clear all stage fields and stall_cnt to 0.
REQ-030 After reset, all outputs SHALL therefore be 0, and hazard SHALL depend only on the ID inputs (which gives 0, since every stage wb_en is 0).
REQ-031 rst asserted while freeze=1 SHALL still clear all state.
REQ-032 The first edge after rst deasserts SHALL behave as a normal edge.

Verification
REQ-033 Scenario 1, load-use: FWRD_EN=1; cycle n: ID is a load with dest=3; cycle n+1: ID has src1=3 used -> hazard=1 for exactly one cycle, EXE gets a bubble, stall_cnt=1; the next cycle hazard=0 and WB_EN_MEM=1 with dest_MEM=3.
REQ-034 Scenario 2, no forwarding: FWRD_EN=0; an ADD writing r5 is followed by an instruction reading src2=5 -> hazard=1 for 2 consecutive cycles (the ADD in EXE, then in MEM), then 0; stall_cnt=2.
REQ-035 Scenario 3, freeze: a hazard is pending and freeze is held 1 for 4 cycles -> all outputs are stable, hazard stays 1 and stall_cnt does not change; after freeze=0 the sequence resumes as in scenario 1.
REQ-036 Scenario 4, flush: flush=1 with ID WB_EN_ID=1 and dest=7 -> the next cycle EXE.wb_en=0; two cycles later WB_EN_MEM=0.
REQ-037 Scenario 5, unused source: FWRD_EN=0, EXE writes r2, ID has src1=2 with src1_used_ID=0 -> hazard=0.
REQ-038 Scenario 6, saturation and reset: force 70000 stall cycles -> stall_cnt=16'hFFFF; pulse rst mid-cycle -> stall_cnt and all outputs read 0 before the next edge.

Source files
------------

// File: rtl/hazard_track_if.sv
// Pipeline hazard-tracker bus: ID-stage inputs, stall request, shadow stage outputs.
// Latency: interface only, no logic.
// Backpressure: hazard is the stall request back to PC/IF/ID; freeze holds the tracker.
interface hazard_track_if;
  logic        FWRD_EN;
  logic        freeze;
  logic        flush;
  logic        WB_EN_ID;
  logic        MEM_R_EN_ID;
  logic [3:0]  dest_ID;
  logic [3:0]  src1_ID;
  logic [3:0]  src2_ID;
  logic        src1_used_ID;
  logic        src2_used_ID;
  logic        hazard;
  logic        WB_EN_MEM;
  logic        WB_EN_WB;
  logic [3:0]  dest_MEM;
  logic [3:0]  dest_WB;
  logic [3:0]  src1_FWRD;
  logic [3:0]  src2_FWRD;
  logic [15:0] stall_cnt;

  // Pipeline control side: drives ID fields, observes stall and shadow stages.
  modport master (
    output FWRD_EN, freeze, flush, WB_EN_ID, MEM_R_EN_ID,
    output dest_ID, src1_ID, src2_ID, src1_used_ID, src2_used_ID,
    input  hazard, WB_EN_MEM, WB_EN_WB, dest_MEM, dest_WB,
    input  src1_FWRD, src2_FWRD, stall_cnt
  );

  // Tracker side.
  modport slave (
    input  FWRD_EN, freeze, flush, WB_EN_ID, MEM_R_EN_ID,
    input  dest_ID, src1_ID, src2_ID, src1_used_ID, src2_used_ID,
    output hazard, WB_EN_MEM, WB_EN_WB, dest_MEM, dest_WB,
    output src1_FWRD, src2_FWRD, stall_cnt
  );
endinterface

// File: rtl/hazard_track.sv
// Data-hazard detector with EXE/MEM/WB shadow registers and a saturating stall counter.
// Latency: hazard is combinational; stage outputs update one clk edge after ID is presented.
// Backpressure: raises hazard to stall PC/IF/ID; freeze holds every register including the counter.
module hazard_track (
  input  logic          clk,
  input  logic          rst,
  hazard_track_if.slave bus
);

  typedef struct packed {
    logic       wb_en;
    logic       mem_r;
    logic [3:0] dest;
  } stage_t;

  typedef struct packed {
    stage_t     st;
    logic [3:0] src1;
    logic [3:0] src2;
  } exe_t;

  exe_t        exe_q, exe_d;
  stage_t      mem_q, mem_d;
  stage_t      wb_q,  wb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic match1_exe, match2_exe, match1_mem, match2_mem;
  logic hazard;

  // WB mem_r is carried along so every stage has the same shape; nothing reads it.
  logic unused_wb_mem_r;
  assign unused_wb_mem_r = wb_q.mem_r;

  // Source-vs-stage dependency matches and the stall decision. WB never
  // stalls because the register file writes on the falling edge.
  always_comb begin
    match1_exe = exe_q.st.wb_en & bus.src1_used_ID & (exe_q.st.dest == bus.src1_ID);
    match2_exe = exe_q.st.wb_en & bus.src2_used_ID & (exe_q.st.dest == bus.src2_ID);
    match1_mem = mem_q.wb_en    & bus.src1_used_ID & (mem_q.dest    == bus.src1_ID);
    match2_mem = mem_q.wb_en    & bus.src2_used_ID & (mem_q.dest    == bus.src2_ID);
    if (bus.FWRD_EN) begin
      // Only a load in EXE cannot be forwarded in time.
      hazard = exe_q.st.mem_r & (match1_exe | match2_exe);
    end else begin
      hazard = match1_exe | match2_exe | match1_mem | match2_mem;
    end
  end

  // Next-state: advance the shadow pipeline unless frozen; stalls and
  // flushes turn the EXE entry into a bubble but still capture its fields.
  always_comb begin
    exe_d       = exe_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    if (!bus.freeze) begin
      wb_d           = mem_q;
      mem_d          = exe_q.st;
      exe_d.st.wb_en = bus.WB_EN_ID    & ~(hazard | bus.flush);
      exe_d.st.mem_r = bus.MEM_R_EN_ID & ~(hazard | bus.flush);
      exe_d.st.dest  = bus.dest_ID;
      exe_d.src1     = bus.src1_ID;
      exe_d.src2     = bus.src2_ID;
      if (hazard && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q       <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      exe_q       <= exe_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.hazard    = hazard;
  assign bus.WB_EN_MEM = mem_q.wb_en;
  assign bus.dest_MEM  = mem_q.dest;
  assign bus.WB_EN_WB  = wb_q.wb_en;
  assign bus.dest_WB   = wb_q.dest;
  assign bus.src1_FWRD = exe_q.src1;
  assign bus.src2_FWRD = exe_q.src2;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
